// File: rtl/bufnb_fifo_if.sv
// Handshake bundle for the bufnb_fifo elastic buffer.
// Producer side: I / I_VLD / I_RDY. Consumer side: O / O_VLD / O_RDY.
// Control and status: FLUSH, CNT, FULL, EMPTY.
interface bufnb_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] I;
  logic             I_VLD;
  logic             I_RDY;
  logic [WIDTH-1:0] O;
  logic             O_VLD;
  logic             O_RDY;
  logic             FLUSH;
  logic [AW:0]      CNT;
  logic             FULL;
  logic             EMPTY;

  // Environment view: the producer, the consumer and flush control.
  modport master (
    output I, I_VLD, O_RDY, FLUSH,
    input  I_RDY, O, O_VLD, CNT, FULL, EMPTY
  );

  // Buffer view.
  modport slave (
    input  I, I_VLD, O_RDY, FLUSH,
    output I_RDY, O, O_VLD, CNT, FULL, EMPTY
  );
endinterface

// File: rtl/bufnb_fifo.sv
// bufnb_fifo: WIDTH-bit, DEPTH-entry first-word fall-through elastic buffer.
// - Status (I_RDY, O_VLD, FULL, EMPTY) is decoded only from the registered
//   occupancy, so no combinational path runs from O_RDY to I_RDY.
// - A word written at one edge becomes visible on O after that edge; there
//   is no same-cycle bypass when the buffer is empty.
// - FLUSH clears pointers and occupancy at the next edge and overrides any
//   concurrent read or write.
// - The storage array is not reset; only the pointers and count are.
module bufnb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  bufnb_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [WIDTH-1:0] o_s;

  assign full_s  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_s = (cnt_q == {(AW+1){1'b0}});
  assign wr_en_s = bus.I_VLD && !full_s;
  assign rd_en_s = bus.O_RDY && !empty_s;

  assign bus.I_RDY = !full_s;
  assign bus.O_VLD = !empty_s;
  assign bus.FULL  = full_s;
  assign bus.EMPTY = empty_s;
  assign bus.CNT   = cnt_q;
  assign bus.O     = o_s;

  // Head-of-buffer data, forced to zero while nothing is stored.
  always_comb begin
    o_s = {WIDTH{1'b0}};
    if (empty_s) begin
      o_s = {WIDTH{1'b0}};
    end else begin
      o_s = mem_q[rd_ptr_q];
    end
  end

  // Next pointers and occupancy; flush wins over any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.FLUSH) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      cnt_d    = {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy state, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; no transfer lands while flushing or held in reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !bus.FLUSH && RST_N) begin
      mem_q[wr_ptr_q] <= bus.I;
    end
  end
endmodule

// File: tb/tb_bufnb_fifo.sv
// Directed self-checking bench for bufnb_fifo (WIDTH=8, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_bufnb_fifo;
  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  bufnb_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  bufnb_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic empty,
                           input logic full, input logic i_rdy, input logic o_vld,
                           input logic [7:0] o);
    chk({tag, ".cnt"},   32'(bus.CNT),   32'(cnt));
    chk({tag, ".empty"}, 32'(bus.EMPTY), 32'(empty));
    chk({tag, ".full"},  32'(bus.FULL),  32'(full));
    chk({tag, ".i_rdy"}, 32'(bus.I_RDY), 32'(i_rdy));
    chk({tag, ".o_vld"}, 32'(bus.O_VLD), 32'(o_vld));
    chk({tag, ".o"},     32'(bus.O),     32'(o));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST_N     = 1'b0;
    bus.I     = 8'h00;
    bus.I_VLD = 1'b0;
    bus.O_RDY = 1'b0;
    bus.FLUSH = 1'b0;

    // Reset then idle.
    #12;
    chk_state("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk_state("idle", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // Fill with four words, consumer stalled.
    bus.I_VLD = 1'b1;
    bus.I = 8'hA1; step();
    chk_state("fill1", 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1);
    bus.I = 8'hB2; step();
    bus.I = 8'hC3; step();
    bus.I = 8'hD4; step();
    chk_state("full", 4, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1);
    bus.I = 8'hE5; step();
    chk_state("full_hold", 4, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1);

    // Drain from full while E5 is offered: read-only edge, then read+write.
    bus.O_RDY = 1'b1;
    step();
    chk_state("pop_a1", 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2);
    step();
    chk_state("rw_e5", 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3);
    bus.I_VLD = 1'b0;
    step();
    chk_state("pop_c3", 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hD4);
    step();
    chk_state("pop_d4", 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hE5);
    step();
    chk_state("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // Continuous stream of ten words across pointer wrap.
    bus.I_VLD = 1'b1;
    bus.I     = 8'h00;
    #1;
    chk("stream.no_bypass", 32'(bus.O_VLD), 32'd0);
    for (int k = 0; k < 10; k++) begin
      bus.I = 8'(k);
      step();
      chk("stream.o",     32'(bus.O),     32'(k));
      chk("stream.cnt",   32'(bus.CNT),   32'd1);
      chk("stream.o_vld", 32'(bus.O_VLD), 32'd1);
    end
    bus.I_VLD = 1'b0;
    step();
    chk_state("stream_end", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    bus.O_RDY = 1'b0;

    // Flush with three words stored and both handshakes offered.
    bus.I_VLD = 1'b1;
    bus.I = 8'h11; step();
    bus.I = 8'h22; step();
    bus.I = 8'h33; step();
    chk_state("pre_flush", 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    bus.FLUSH = 1'b1;
    bus.I     = 8'h77;
    bus.O_RDY = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    bus.I_VLD = 1'b0;
    bus.O_RDY = 1'b0;
    chk_state("flushed", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk_state("flush_idle", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    bus.I_VLD = 1'b1;
    bus.I     = 8'h66;
    step();
    bus.I_VLD = 1'b0;
    chk_state("post_flush_wr", 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
    bus.O_RDY = 1'b1;
    step();
    bus.O_RDY = 1'b0;
    chk_state("post_flush_rd", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset with two words stored.
    bus.I_VLD = 1'b1;
    bus.I = 8'h31; step();
    bus.I = 8'h32; step();
    bus.I_VLD = 1'b0;
    chk_state("pre_reset", 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31);
    #2;
    RST_N = 1'b0;
    #1;
    chk_state("async_reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.I_VLD = 1'b1;
    bus.I     = 8'h5A;
    step();
    bus.I_VLD = 1'b0;
    chk_state("after_reset_wr", 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
